// File: rtl/vreg_read_port_ctrl.sv
// Initiator for one vector-register-file read port: waits for the port, streams a vector into a FIFO, replays it to a FU.
// Optional stall counter output enabled by defining VREG_RD_PERF_EN.
module vreg_read_port_ctrl #(
  parameter int unsigned MVL            = 32,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned NUM_READ_PORTS = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned VALID          = 1,
  parameter int unsigned PORT           = 0,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 req_valid,
  output logic                                                 req_ready,
  input  logic [$clog2(NUM_REGS)-1:0]                          req_reg,
  input  logic [$clog2(MVL):0]                                 req_vl,
  input  logic [NUM_REGS*NUM_READ_PORTS*(DATA_WIDTH+VALID)-1:0] rd_i,
  input  logic [NUM_REGS*NUM_READ_PORTS-1:0]                   busy_read_i,
  output logic [NUM_REGS*NUM_READ_PORTS-1:0]                   r_signal_o,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [DATA_WIDTH-1:0]                                out_data,
  output logic [$clog2(MVL)-1:0]                               out_idx,
  output logic                                                 out_last,
  output logic                                                 done
`ifdef VREG_RD_PERF_EN
  ,
  output logic [31:0]                                          stall_cnt_o
`endif
);

  localparam int unsigned REG_W  = $clog2(NUM_REGS);
  localparam int unsigned VL_W   = $clog2(MVL) + 1;
  localparam int unsigned IDX_W  = $clog2(MVL);
  localparam int unsigned ELEM_W = DATA_WIDTH + VALID;
  localparam int unsigned NBITS  = NUM_REGS * NUM_READ_PORTS;
  localparam int unsigned SEL_W  = $clog2(NBITS);
  localparam int unsigned BASE_W = $clog2(NBITS * ELEM_W);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [REG_W-1:0]      reg_q, reg_d;
  logic [VL_W-1:0]       vl_q, vl_d, rx_q, rx_d, tx_q, tx_d;
  logic                  rsig_q, rsig_d, done_q, done_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [SEL_W-1:0]      sel;
  logic [BASE_W-1:0]     base;
  logic [ELEM_W-1:0]     elem;
  logic                  push, pop, overflow;

  always_comb begin
    sel  = SEL_W'(32'(reg_q) * NUM_READ_PORTS + PORT);
    base = BASE_W'(32'(sel) * ELEM_W);
    elem = rd_i[base +: ELEM_W];

    pop      = (cnt_q != '0) && out_ready;
    push     = (state_q == S_STREAM) && elem[ELEM_W-1] && (rx_q < vl_q);
    overflow = push && !pop && (cnt_q == CNT_W'(FIFO_DEPTH));

    state_d  = state_q;
    reg_d    = reg_q;
    vl_d     = vl_q;
    rx_d     = push ? rx_q + VL_W'(1) : rx_q;
    tx_d     = pop ? tx_q + VL_W'(1) : tx_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: if (req_valid) begin
        reg_d = req_reg;
        vl_d  = req_vl;
        rx_d  = '0;
        tx_d  = '0;
        if (req_vl == '0) done_d = 1'b1;
        else              state_d = S_WAIT;
      end
      S_WAIT:   if (!busy_read_i[sel]) state_d = S_STREAM;
      S_STREAM: if (rx_d == vl_q) state_d = S_DRAIN;
      S_DRAIN:  if (tx_d == vl_q) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase

    // Requests are issued against next-cycle occupancy plus the one element still in flight,
    // so two free slots always cover the outstanding and the newly requested element.
    rsig_d = (state_d == S_STREAM)
          && ((CNT_W'(FIFO_DEPTH) - cnt_d) >= CNT_W'(2))
          && ((rx_d + VL_W'(rsig_q)) < vl_q);

    r_signal_o      = '0;
    r_signal_o[sel] = rsig_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      reg_q    <= '0;
      vl_q     <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      rsig_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      reg_q    <= reg_d;
      vl_q     <= vl_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      rsig_q   <= rsig_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= elem[DATA_WIDTH-1:0];
  end

  assign req_ready = (state_q == S_IDLE);
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_idx   = tx_q[IDX_W-1:0];
  assign out_last  = out_valid && (tx_q == vl_q - VL_W'(1));
  assign done      = done_q;

  ovf_never: assert property (@(posedge clk) disable iff (!rst) !overflow);

`ifdef VREG_RD_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && req_valid)
      stall_d = '0;
    else if ((state_q == S_WAIT
              || (state_q == S_STREAM && !rsig_q && (CNT_W'(FIFO_DEPTH) - cnt_q) < CNT_W'(2)))
             && stall_q != '1)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_vreg_read_port_ctrl.sv
// Directed bench for vreg_read_port_ctrl with a behavioural register-bank responder and an in-order output monitor.
module tb_vreg_read_port_ctrl;

  localparam int unsigned EW = 33;
  localparam int unsigned NB = 128;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [4:0]     req_reg = '0;
  logic [5:0]     req_vl = '0;
  logic [NB*EW-1:0] rd_i;
  logic [NB-1:0]  busy_read_i = '0;
  logic [NB-1:0]  r_signal_o;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [31:0]    out_data;
  logic [4:0]     out_idx;
  logic           out_last;
  logic           done;
`ifdef VREG_RD_PERF_EN
  logic [31:0]    stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          bank_bit   = 20;
  logic [31:0] bank_base  = 32'h0;
  int          bank_vl    = 0;
  int          bank_extra = 0;
  int          bank_ptr   = 0;
  int          bank_xsent = 0;
  logic [NB*EW-1:0] bank_nxt;

  int mon_cnt      = 0;
  int mon_last_cyc = 0;
  int exp_vl       = 0;
  int done_cyc;

  vreg_read_port_ctrl #(
    .MVL(32), .NUM_REGS(32), .NUM_READ_PORTS(4), .DATA_WIDTH(32),
    .VALID(1), .PORT(0), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg), .req_vl(req_vl),
    .rd_i(rd_i), .busy_read_i(busy_read_i), .r_signal_o(r_signal_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .done(done)
`ifdef VREG_RD_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bank: one element per granted cycle, 1-cycle latency; neighbouring slices carry always-valid noise.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_i       <= '0;
      bank_ptr   <= 0;
      bank_xsent <= 0;
    end else begin
      bank_nxt = '0;
      bank_nxt[(bank_bit+1)*EW +: EW] = {1'b1, 32'hBAD0_0001};
      bank_nxt[(bank_bit+4)*EW +: EW] = {1'b1, 32'hBAD0_0004};
      if (req_valid && req_ready) begin
        bank_ptr   <= 0;
        bank_xsent <= 0;
      end else if (r_signal_o[bank_bit]) begin
        bank_nxt[bank_bit*EW +: EW] = {1'b1, bank_base + 32'(bank_ptr)};
        bank_ptr <= bank_ptr + 1;
      end else if (bank_ptr >= bank_vl && bank_xsent < bank_extra) begin
        bank_nxt[bank_bit*EW +: EW] = {1'b1, 32'hDEAD_0000 + 32'(bank_xsent)};
        bank_xsent <= bank_xsent + 1;
      end
      rd_i <= bank_nxt;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (req_valid && req_ready) begin
        mon_cnt = 0;
      end else if (out_valid && out_ready) begin
        check_eq("out_data", out_data, bank_base + 32'(mon_cnt));
        check_eq("out_idx", out_idx, mon_cnt);
        check_eq("out_last", out_last, mon_cnt == exp_vl - 1);
        mon_cnt      = mon_cnt + 1;
        mon_last_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input int vl, input logic [31:0] b, input int extra);
    bank_bit   = r * 4;
    bank_base  = b;
    bank_vl    = vl;
    bank_extra = extra;
    exp_vl     = vl;
    req_reg    = 5'(r);
    req_vl     = 6'(vl);
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int at_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    at_cyc = cyc;
    check_eq({tag, "_done_seen"}, seen, 1);
    check_eq({tag, "_ready_at_done"}, req_ready, 1);
  endtask

  task automatic check_done_drop(input string tag);
    @(negedge clk);
    check_eq({tag, "_done_1cyc"}, done, 0);
  endtask

  initial begin
    repeat (3) step();
    check_eq("rst_rsig", r_signal_o, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_req_ready", req_ready, 1);
    rst = 1'b1;
    step();

    // Basic 4-element vector from register 5
    issue(5, 4, 32'hA0, 0);
    @(negedge clk);
    check_eq("t1_wait_rsig", r_signal_o, 0);
    @(negedge clk);
    check_eq("t1_rsig_bit20", r_signal_o, 128'(1) << 20);
    wait_done("t1", done_cyc);
    check_eq("t1_done_lat", done_cyc, mon_last_cyc + 1);
    check_eq("t1_count", mon_cnt, 4);
    check_done_drop("t1");

    // Zero-length vector
    step();
    issue(6, 0, 32'h0, 0);
    @(negedge clk);
    check_eq("t2_done", done, 1);
    check_eq("t2_rsig", r_signal_o, 0);
    check_eq("t2_out_valid", out_valid, 0);
    check_eq("t2_req_ready", req_ready, 1);
    check_done_drop("t2");
    check_eq("t2_count", mon_cnt, 0);

    // Port busy for several cycles after accept
    step();
    busy_read_i[20] = 1'b1;
    issue(5, 5, 32'hB0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("t3_busy_rsig", r_signal_o, 0);
    end
    step();
    busy_read_i[20] = 1'b0;
    @(negedge clk);
    check_eq("t3_rsig_still_wait", r_signal_o, 0);
    @(negedge clk);
    check_eq("t3_rsig_after", r_signal_o, 128'(1) << 20);
    wait_done("t3", done_cyc);
    check_eq("t3_count", mon_cnt, 5);
`ifdef VREG_RD_PERF_EN
    check_eq("t3_stall_cnt", stall_cnt_o, 7);
`endif
    check_done_drop("t3");

    // Full-length vector with consumer stalled: FIFO fills to depth, no loss
    step();
    out_ready = 1'b0;
    issue(3, 32, 32'h100, 0);
    repeat (20) @(negedge clk);
    check_eq("t4_fill_requests", bank_ptr, 8);
    check_eq("t4_rsig_low", r_signal_o, 0);
    check_eq("t4_out_valid", out_valid, 1);
    check_eq("t4_head_data", out_data, 32'h100);
    check_eq("t4_head_idx", out_idx, 0);
    step();
    out_ready = 1'b1;
    wait_done("t4", done_cyc);
    check_eq("t4_count", mon_cnt, 32);
    check_done_drop("t4");

    // Bank over-delivers two elements past the end
    step();
    issue(7, 5, 32'h300, 2);
    wait_done("t5", done_cyc);
    check_eq("t5_count", mon_cnt, 5);
    repeat (4) @(negedge clk);
    check_eq("t5_extras_sent", bank_xsent, 2);
    check_eq("t5_no_extra_out", mon_cnt, 5);
    check_eq("t5_out_valid", out_valid, 0);

    // Asynchronous reset mid-stream, then a clean request
    step();
    out_ready = 1'b0;
    issue(5, 16, 32'h500, 0);
    repeat (4) @(negedge clk);
    check_eq("t6_pre_rsig", r_signal_o, 128'(1) << 20);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("t6_rst_rsig", r_signal_o, 0);
    check_eq("t6_rst_out_valid", out_valid, 0);
    check_eq("t6_rst_done", done, 0);
    check_eq("t6_rst_req_ready", req_ready, 1);
    step();
    step();
    rst = 1'b1;
    step();
    out_ready = 1'b1;
    issue(5, 4, 32'h600, 0);
    wait_done("t6", done_cyc);
    check_eq("t6_count", mon_cnt, 4);
    check_done_drop("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/vreg_read_port_ctrl.md
Name: vreg_read_port_ctrl

Overview:
- Initiator side of one vector register file read port; the register bank itself is the responder.
- Accepts an operand request (register index, vector length), waits until the selected register's read port is free, then drives that port's r_signal bit and collects the streamed data+valid elements.
- Buffers collected elements in an internal FIFO and presents them to a functional unit as a valid/ready element stream with index and last flag.
- One instance per (functional unit operand, read port) pair.

Parameters:
- MVL, 32, maximum vector length in elements.
- NUM_REGS, 32, number of vector registers.
- NUM_READ_PORTS, 4, read ports per register.
- DATA_WIDTH, 32, element data width.
- VALID, 1, valid-bit width per element on the read bus (fixed at 1).
- PORT, 0, read port index owned by this instance (0..NUM_READ_PORTS-1).
- FIFO_DEPTH, 8, element buffer depth; power of two, minimum 4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  operand request valid.
- req_ready  out  1  controller idle, request accepted when req_valid && req_ready.
- req_reg  in  bitwidth(NUM_REGS)  source register index.
- req_vl  in  bitwidth(MVL)+1  element count, 0..MVL.
- rd_i  in  NUM_REGS*NUM_READ_PORTS*(DATA_WIDTH+VALID)  register bank read bus.
- busy_read_i  in  NUM_REGS*NUM_READ_PORTS  per-register, per-port busy flags.
- r_signal_o  out  NUM_REGS*NUM_READ_PORTS  read enables; only bit req_reg*NUM_READ_PORTS+PORT is ever driven, all others constant 0.
- out_valid  out  1  element available.
- out_ready  in  1  consumer accepts element.
- out_data  out  DATA_WIDTH  element data.
- out_idx  out  bitwidth(MVL)  element index within the vector.
- out_last  out  1  element is index vl-1.
- done  out  1  one-cycle pulse when the request has been fully delivered.

Behaviour:
- Slice for register r, port p: rd_i[(r*NUM_READ_PORTS+p)*(DATA_WIDTH+VALID) +: DATA_WIDTH+VALID]. The valid bit is the MSB; data is [DATA_WIDTH-1:0]. The r_signal bit for (r,p) is r*NUM_READ_PORTS+p.
- Bus protocol: while the r_signal bit is high, the bank delivers at most one element per cycle, with 1-cycle latency. While it is low, the bank holds its element pointer; the one element already in flight may still arrive.
- Reset: state IDLE; r_signal_o=0, out_valid=0, done=0, req_ready=1; FIFO empty; counters 0.
- State machine:
  - IDLE: req_ready=1. On accept, latch reg and vl, clear rx_cnt and tx_cnt. If vl==0, pulse done next cycle and stay IDLE. Otherwise go to WAIT.
  - WAIT: remain while busy_read_i[reg*NUM_READ_PORTS+PORT]==1. When it is 0, go to STREAM.
  - STREAM: the registered r_signal bit is high when FIFO free entries >= 2 and rx_cnt + in-flight < vl; otherwise low.
    - Each cycle the slice valid bit is 1 and rx_cnt<vl: push data, rx_cnt++.
    - Valid elements arriving after rx_cnt==vl are discarded.
    - When rx_cnt reaches vl: r_signal low, go to DRAIN.
  - DRAIN: wait until tx_cnt==vl (FIFO empty). Then pulse done for 1 cycle and go to IDLE.
- Output stream:
  - out_valid = FIFO not empty; out_data = FIFO head; out_idx = tx_cnt.
  - out_last = (tx_cnt==vl-1) && out_valid.
  - A pop happens on out_valid && out_ready and increments tx_cnt.
  - out_data and out_idx hold stable while out_valid && !out_ready.
- FIFO: simultaneous push and pop when full is not possible, because of the 2-entry headroom rule. Push and pop in the same cycle keep the count unchanged. Pointers wrap mod FIFO_DEPTH.
- Overflow never occurs; the internal assertion overflow must stay 0.
- Pop and push may overlap across states (STREAM/DRAIN).
- New requests are not accepted until done has pulsed.
- An async reset asserted mid-operation clears everything immediately. r_signal_o drops in the same cycle, without waiting for a clock edge.

Optional Feature:
- Macro VREG_RD_PERF_EN.
- Defined:
  - Adds output stall_cnt_o (32 bits, reset 0), saturating.
  - It increments each cycle in WAIT, and each cycle in STREAM with r_signal low because of FIFO headroom.
  - It clears on request accept.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- reg=5, vl=4, PORT=0, busy=0, bank streams 0xA0..0xA3, out_ready=1 -> r_signal_o bit 20 high; out_data A0..A3 with idx 0..3; out_last on idx 3; done 1 cycle after last pop.
- vl=0 request -> r_signal_o stays 0, no out_valid, done pulses once, req_ready back to 1.
- busy_read_i bit 20 high for 6 cycles after accept -> r_signal stays 0 for those 6 cycles, then asserts; all elements delivered in order.
- vl=32, out_ready=0 for 20 cycles -> FIFO fills to 8 entries max; r_signal low while free entries <2; no data loss; all 32 delivered in order after out_ready=1.
- Bank returns 2 extra valid elements after the vl-th element -> extras discarded; exactly vl outputs.
- rst low mid-STREAM -> r_signal_o, out_valid and done go 0 at once; after release, req_ready=1 and a new request completes normally.
